// File: rtl/multi_edge_pulse_pkg.sv
// ----------------------------------------------------------------------------
// multi_edge_pulse_pkg
// Shared types and constants for the multi-channel edge-to-pulse converter.
//   edge_mode_e : per-channel edge selection (rise / fall / both / off)
//   SYNC_STAGES : depth of the optional input synchronizer
//                 (used only when LEVEL_PULSE_SYNC_EN is defined)
// ----------------------------------------------------------------------------
package multi_edge_pulse_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    localparam int SYNC_STAGES = 2;

endpackage : multi_edge_pulse_pkg

// File: rtl/multi_edge_pulse_chan.sv
// ----------------------------------------------------------------------------
// edge_pulse_chan
// One channel of the edge-to-pulse converter: optional synchronizer, history
// register, arming flag, retriggerable pulse counter and sticky overrun flag.
//
// Optional feature: define LEVEL_PULSE_SYNC_EN to pass the level input
// through a SYNC_STAGES-deep synchronizer before edge detection.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   level     in   level input for this channel
//   mode      in   edge selection (edge_mode_e)
//   ovr_clr   in   single-cycle clear of the overrun flag
//   pulse     out  registered output pulse
//   pulse_nxt out  next-state value of pulse (feeds the top-level OR register)
//   ovr       out  sticky overrun flag
// ----------------------------------------------------------------------------
module edge_pulse_chan
    import multi_edge_pulse_pkg::*;
#(
    parameter int PULSE_W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level,
    input  edge_mode_e mode,
    input  logic       ovr_clr,
    output logic       pulse,
    output logic       pulse_nxt,
    output logic       ovr
);

    localparam int CNT_W = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W);

    logic             s;
    logic             hist;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovr_nxt;
    logic             edge_det;

`ifdef LEVEL_PULSE_SYNC_EN
    // Synchronizer: sync_p[0] is the first flop, the last stage feeds edge detect.
    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], level};
        end
    end

    assign s = sync_p[SYNC_STAGES-1];
`else
    assign s = level;
`endif

    always_comb begin
        edge_det = 1'b0;
        ovr_nxt  = ovr;
        cnt_nxt  = cnt;

        // Unarmed (first edge after reset) the history is not yet valid.
        if (armed) begin
            unique case (mode)
                EDGE_RISE: edge_det = s & ~hist;
                EDGE_FALL: edge_det = ~s & hist;
                EDGE_BOTH: edge_det = s ^ hist;
                default:   edge_det = 1'b0;
            endcase
        end

        // Disabling a channel kills any pulse in flight.
        if (mode == EDGE_OFF) begin
            cnt_nxt = '0;
        end else if (edge_det) begin
            cnt_nxt = CNT_LOAD;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end

        // A retrigger outranks a simultaneous clear.
        if (edge_det && (cnt != '0)) begin
            ovr_nxt = 1'b1;
        end else if (ovr_clr) begin
            ovr_nxt = 1'b0;
        end
    end

    assign pulse_nxt = (cnt_nxt != '0);

    // History keeps tracking in every mode so re-enabling sees a fresh value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            hist  <= s;
            armed <= 1'b1;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            ovr   <= ovr_nxt;
        end
    end

endmodule : edge_pulse_chan

// File: rtl/multi_edge_pulse.sv
// ----------------------------------------------------------------------------
// multi_edge_pulse
// N-channel level-to-pulse converter. Each channel emits a PULSE_W-cycle
// registered pulse on its selected edge, retriggers on edges during a pulse
// and flags such retriggers in a sticky overrun bit.
//
// Optional feature: LEVEL_PULSE_SYNC_EN adds a 2-flop synchronizer per input.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   level_i      in   [N_CH]     level inputs
//   mode_i       in   [2*N_CH]   per-channel mode, channel c at [2c+1:2c]
//                                00 rise, 01 fall, 10 both, 11 disabled
//   ovr_clr_i    in   [N_CH]     per-channel overrun clear
//   pulse_o      out  [N_CH]     registered pulses
//   any_pulse_o  out             registered OR of pulse_o, cycle-aligned
//   ovr_o        out  [N_CH]     sticky overrun flags
// ----------------------------------------------------------------------------
module multi_edge_pulse
    import multi_edge_pulse_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PULSE_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   level_i,
    input  logic [2*N_CH-1:0] mode_i,
    input  logic [N_CH-1:0]   ovr_clr_i,
    output logic [N_CH-1:0]   pulse_o,
    output logic              any_pulse_o,
    output logic [N_CH-1:0]   ovr_o
);

    logic [N_CH-1:0] pulse_nxt;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        edge_pulse_chan #(
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .level     (level_i[c]),
            .mode      (edge_mode_e'(mode_i[2*c +: 2])),
            .ovr_clr   (ovr_clr_i[c]),
            .pulse     (pulse_o[c]),
            .pulse_nxt (pulse_nxt[c]),
            .ovr       (ovr_o[c])
        );
    end

    // Built from next-state pulses so it lines up with pulse_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pulse_o <= 1'b0;
        end else begin
            any_pulse_o <= |pulse_nxt;
        end
    end

endmodule : multi_edge_pulse

// File: tb/tb_multi_edge_pulse.sv
module tb_multi_edge_pulse;

    localparam int N_CH    = 4;
    localparam int PULSE_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   level_i;
    logic [2*N_CH-1:0] mode_i;
    logic [N_CH-1:0]   ovr_clr_i;
    logic [N_CH-1:0]   pulse_o;
    logic              any_pulse_o;
    logic [N_CH-1:0]   ovr_o;

    int errors = 0;
    int checks = 0;

    // mode_i = {ch3, ch2, ch1, ch0}: ch0 rise, ch1 fall, ch2 both, ch3 rise
    localparam logic [7:0] MODE_RUN = 8'b00_10_01_00;
    localparam logic [7:0] MODE_OFF = 8'b11_11_11_11;
    localparam logic [7:0] MODE_C3X = 8'b11_10_01_00;

    multi_edge_pulse #(
        .N_CH    (N_CH),
        .PULSE_W (PULSE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .level_i     (level_i),
        .mode_i      (mode_i),
        .ovr_clr_i   (ovr_clr_i),
        .pulse_o     (pulse_o),
        .any_pulse_o (any_pulse_o),
        .ovr_o       (ovr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] p, input logic [3:0] o);
        chk({tag, ".pulse"}, 32'(pulse_o), 32'(p));
        chk({tag, ".any"},   32'(any_pulse_o), 32'(|p));
        chk({tag, ".ovr"},   32'(ovr_o), 32'(o));
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        level_i   = 4'hF;
        mode_i    = 8'b10_10_10_10;
        ovr_clr_i = 4'h0;
        #2;
        expect_out("reset", 4'h0, 4'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Inputs high at release: no pulse, even in both-edge mode.
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out($sformatf("arm_hi%0d", i), 4'h0, 4'h0);
        end

        // Bring all levels low with every channel disabled.
        mode_i  = MODE_OFF;
        level_i = 4'h0;
        tick();
        expect_out("off_fall", 4'h0, 4'h0);
        mode_i = MODE_RUN;
        tick();
        tick();
        expect_out("run_idle", 4'h0, 4'h0);

        // ch0 rise: 3-cycle pulse starting at the sampling edge.
        level_i[0] = 1'b1;
        tick(); expect_out("c0_k0", 4'h1, 4'h0);
        tick(); expect_out("c0_k1", 4'h1, 4'h0);
        tick(); expect_out("c0_k2", 4'h1, 4'h0);
        tick(); expect_out("c0_k3", 4'h0, 4'h0);
        level_i[0] = 1'b0;
        tick(); expect_out("c0_fall", 4'h0, 4'h0);
        tick(); expect_out("c0_fall2", 4'h0, 4'h0);

        // ch1 fall: rise ignored, fall produces pulse.
        level_i[1] = 1'b1;
        tick(); expect_out("c1_rise", 4'h0, 4'h0);
        level_i[1] = 1'b0;
        tick(); expect_out("c1_k0", 4'h2, 4'h0);
        tick(); expect_out("c1_k1", 4'h2, 4'h0);
        tick(); expect_out("c1_k2", 4'h2, 4'h0);
        tick(); expect_out("c1_k3", 4'h0, 4'h0);

        // ch2 both: rise then fall -> extended pulse and overrun.
        level_i[2] = 1'b1;
        tick(); expect_out("c2_k0", 4'h4, 4'h0);
        level_i[2] = 1'b0;
        tick(); expect_out("c2_k1", 4'h4, 4'h4);
        tick(); expect_out("c2_k2", 4'h4, 4'h4);
        tick(); expect_out("c2_k3", 4'h4, 4'h4);
        tick(); expect_out("c2_k4", 4'h0, 4'h4);
        tick(); expect_out("c2_k5", 4'h0, 4'h4);
        ovr_clr_i[2] = 1'b1;
        tick(); expect_out("c2_clr", 4'h0, 4'h0);
        ovr_clr_i[2] = 1'b0;

        // Clear coincident with retrigger: set wins.
        level_i[2] = 1'b1;
        tick(); expect_out("c2_r0", 4'h4, 4'h0);
        level_i[2]   = 1'b0;
        ovr_clr_i[2] = 1'b1;
        tick(); expect_out("c2_setwin", 4'h4, 4'h4);
        ovr_clr_i[2] = 1'b0;
        tick();
        tick();
        tick(); expect_out("c2_drain", 4'h0, 4'h4);

        // ch3 rise, then disabled one cycle in: pulse killed at next edge.
        level_i[3] = 1'b1;
        tick(); expect_out("c3_k0", 4'h8, 4'h4);
        mode_i = MODE_C3X;
        tick(); expect_out("c3_off", 4'h0, 4'h4);
        mode_i = MODE_RUN;
        tick(); expect_out("c3_reen0", 4'h0, 4'h4);
        tick(); expect_out("c3_reen1", 4'h0, 4'h4);

        // Async reset mid-pulse on ch0.
        level_i[0] = 1'b1;
        tick(); expect_out("c0_pre_rst", 4'h1, 4'h4);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 4'h0, 4'h0);
        tick();
        rst_n = 1'b1;
        tick(); expect_out("rearm0", 4'h0, 4'h0);
        tick(); expect_out("rearm1", 4'h0, 4'h0);

        // After re-arming a fresh ch0 rise pulses again.
        level_i[0] = 1'b0;
        tick(); expect_out("c0_low", 4'h0, 4'h0);
        level_i[0] = 1'b1;
        tick(); expect_out("c0_again", 4'h1, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_edge_pulse
